stage_ex: RTL and testbench

- Execute stage directly downstream of the issue stage.
- Accepts one issued instruction per cycle with operands already read from the PRF.
- Computes integer ALU results in a single cycle; computes RV32M multiply results in a pipelined multiplier of MULT_STAGES cycles.
- Arbitrates both result sources onto the single CDB that feeds the map table, RS, ROB and PRF write port.

---
 rtl/stage_ex.sv | 174 +++++++++++++++++
 tb/tb_stage_ex.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex.sv
// Execute stage: single-cycle integer ALU plus pipelined RV32M multiplier,
// both arbitrated onto the single CDB (multiplier has priority).
module stage_ex #(
    parameter int XLEN          = 32,
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_BITS      = 5,
    parameter int MULT_STAGES   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic                     is_valid,
    input  logic [PHYS_REG_BITS-1:0] is_tag,
    input  logic [ROB_BITS-1:0]      is_rob_idx,
    input  logic [XLEN-1:0]          is_rs1_val,
    input  logic [XLEN-1:0]          is_rs2_val,
    input  logic [XLEN-1:0]          is_imm,
    input  logic                     is_use_imm,
    input  logic                     is_is_mult,
    input  logic [3:0]               is_alu_func,
    input  logic [1:0]               is_mult_func,
    output logic                     ex_is_ready,
    output logic                     cdb_valid,
    output logic [PHYS_REG_BITS-1:0] cdb_tag,
    output logic [ROB_BITS-1:0]      cdb_rob_idx,
    output logic [XLEN-1:0]          cdb_value
);

    localparam int PW   = 2 * XLEN;
    localparam int CW   = (PW + MULT_STAGES - 1) / MULT_STAGES;
    localparam int LAST = MULT_STAGES - 1;
    localparam int SHW  = $clog2(XLEN);

    typedef struct packed {
        logic [PHYS_REG_BITS-1:0] tag;
        logic [ROB_BITS-1:0]      rob;
        logic [1:0]               func;
        logic [PW-1:0]            a;
        logic [PW-1:0]            b;
        logic [PW-1:0]            acc;
    } mstage_t;

    // Each stage adds one CW-bit slice of operand B; sums wrap mod 2^PW.
    function automatic logic [PW-1:0] partial(
        input logic [PW-1:0] a,
        input logic [PW-1:0] b,
        input int            s
    );
        logic [PW-1:0] chunk;
        chunk = (b >> (s * CW)) & ({PW{1'b1}} >> (PW - CW));
        return (a * chunk) << (s * CW);
    endfunction

    mstage_t                  ms     [MULT_STAGES];
    mstage_t                  ms_nxt [MULT_STAGES];
    logic [MULT_STAGES-1:0]   mv;
    logic [MULT_STAGES-1:0]   mv_nxt;

    logic                     alu_v;
    logic [PHYS_REG_BITS-1:0] alu_tag;
    logic [ROB_BITS-1:0]      alu_rob;
    logic [XLEN-1:0]          alu_val;

    logic                     accept;
    logic                     alu_acc;
    logic                     mult_acc;
    logic [XLEN-1:0]          op_b;
    logic [SHW-1:0]           shamt;
    logic [XLEN-1:0]          alu_res;
    logic                     a_sx;
    logic                     b_sx;
    logic [PW-1:0]            opa;
    logic [PW-1:0]            opb;
    logic [XLEN-1:0]          mult_res;

    assign ex_is_ready = !alu_v || !mv[LAST];
    assign accept      = is_valid && ex_is_ready && !squash;
    assign alu_acc     = accept && !is_is_mult;
    assign mult_acc    = accept && is_is_mult;

    assign op_b  = is_use_imm ? is_imm : is_rs2_val;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        unique case (is_alu_func)
            4'd0:    alu_res = is_rs1_val + op_b;
            4'd1:    alu_res = is_rs1_val - op_b;
            4'd2:    alu_res = XLEN'($signed(is_rs1_val) < $signed(op_b));
            4'd3:    alu_res = XLEN'(is_rs1_val < op_b);
            4'd4:    alu_res = is_rs1_val & op_b;
            4'd5:    alu_res = is_rs1_val | op_b;
            4'd6:    alu_res = is_rs1_val ^ op_b;
            4'd7:    alu_res = is_rs1_val << shamt;
            4'd8:    alu_res = is_rs1_val >> shamt;
            4'd9:    alu_res = $signed(is_rs1_val) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
    assign a_sx = (is_mult_func == 2'd1) || (is_mult_func == 2'd2);
    assign b_sx = (is_mult_func == 2'd1);
    assign opa  = {{XLEN{a_sx & is_rs1_val[XLEN-1]}}, is_rs1_val};
    assign opb  = {{XLEN{b_sx & is_rs2_val[XLEN-1]}}, is_rs2_val};

    always_comb begin
        ms_nxt[0].tag  = is_tag;
        ms_nxt[0].rob  = is_rob_idx;
        ms_nxt[0].func = is_mult_func;
        ms_nxt[0].a    = opa;
        ms_nxt[0].b    = opb;
        ms_nxt[0].acc  = partial(opa, opb, 0);
        mv_nxt[0]      = mult_acc;
        for (int i = 1; i < MULT_STAGES; i++) begin
            ms_nxt[i]     = ms[i-1];
            ms_nxt[i].acc = ms[i-1].acc
                          + partial(ms[i-1].a, ms[i-1].b, i);
            mv_nxt[i]     = mv[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mv <= '0;
            for (int i = 0; i < MULT_STAGES; i++) begin
                ms[i] <= '0;
            end
        end else begin
            mv <= squash ? '0 : mv_nxt;
            ms <= ms_nxt;
        end
    end

    // The buffer only drains when the multiplier last stage is empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_v   <= 1'b0;
            alu_tag <= '0;
            alu_rob <= '0;
            alu_val <= '0;
        end else if (squash) begin
            alu_v <= 1'b0;
        end else if (alu_acc) begin
            alu_v   <= 1'b1;
            alu_tag <= is_tag;
            alu_rob <= is_rob_idx;
            alu_val <= alu_res;
        end else if (!mv[LAST]) begin
            alu_v <= 1'b0;
        end
    end

    assign mult_res = (ms[LAST].func == 2'd0) ? ms[LAST].acc[XLEN-1:0]
                                              : ms[LAST].acc[PW-1:XLEN];

    assign cdb_valid = !squash && (mv[LAST] || alu_v);

    always_comb begin
        cdb_tag     = '0;
        cdb_rob_idx = '0;
        cdb_value   = '0;
        if (mv[LAST]) begin
            cdb_tag     = ms[LAST].tag;
            cdb_rob_idx = ms[LAST].rob;
            cdb_value   = mult_res;
        end else if (alu_v) begin
            cdb_tag     = alu_tag;
            cdb_rob_idx = alu_rob;
            cdb_value   = alu_val;
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: scoreboard of expected CDB broadcasts
// with the cycle each must appear in.
module tb_stage_ex;

    localparam int MS = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic        is_valid;
    logic [5:0]  is_tag;
    logic [4:0]  is_rob_idx;
    logic [31:0] is_rs1_val;
    logic [31:0] is_rs2_val;
    logic [31:0] is_imm;
    logic        is_use_imm;
    logic        is_is_mult;
    logic [3:0]  is_alu_func;
    logic [1:0]  is_mult_func;
    logic        ex_is_ready;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [4:0]  cdb_rob_idx;
    logic [31:0] cdb_value;

    stage_ex #(
        .XLEN(32),
        .PHYS_REG_BITS(6),
        .ROB_BITS(5),
        .MULT_STAGES(MS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .is_valid(is_valid),
        .is_tag(is_tag),
        .is_rob_idx(is_rob_idx),
        .is_rs1_val(is_rs1_val),
        .is_rs2_val(is_rs2_val),
        .is_imm(is_imm),
        .is_use_imm(is_use_imm),
        .is_is_mult(is_is_mult),
        .is_alu_func(is_alu_func),
        .is_mult_func(is_mult_func),
        .ex_is_ready(ex_is_ready),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_rob_idx(cdb_rob_idx),
        .cdb_value(cdb_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  tag;
        logic [4:0]  rob;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [5:0] tag, input logic [4:0] rob,
                        input logic [31:0] val, input int due);
        exp_t e;
        e.tag = tag;
        e.rob = rob;
        e.val = val;
        e.due = due;
        q.push_back(e);
    endtask

    task automatic check_cdb();
        exp_t e;
        if (squash) begin
            chk("squash_valid", 64'(cdb_valid), 64'd0);
        end else if (cdb_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 64'(cdb_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("cdb_tag", 64'(cdb_tag), 64'(e.tag));
                chk("cdb_rob", 64'(cdb_rob_idx), 64'(e.rob));
                chk("cdb_value", 64'(cdb_value), 64'(e.val));
                chk("cdb_cycle", 64'(cyc), 64'(e.due));
            end
        end else begin
            chk("idle_tag", 64'(cdb_tag), 64'd0);
            chk("idle_rob", 64'(cdb_rob_idx), 64'd0);
            chk("idle_value", 64'(cdb_value), 64'd0);
            if (q.size() > 0 && q[0].due <= cyc) begin
                chk("missing_valid", 64'(cdb_valid), 64'd1);
                e = q.pop_front();
            end
        end
    endtask

    task automatic tick(input logic sq = 1'b0);
        @(posedge clock);
        cyc++;
        #1;
        squash = sq;
        #1;
        check_cdb();
    endtask

    task automatic idle();
        is_valid = 1'b0;
    endtask

    task automatic set_alu(input logic [5:0] tag, input logic [4:0] rob,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic ui,
                           input logic [3:0] f);
        is_valid    = 1'b1;
        is_is_mult  = 1'b0;
        is_tag      = tag;
        is_rob_idx  = rob;
        is_rs1_val  = a;
        is_rs2_val  = b;
        is_imm      = imm;
        is_use_imm  = ui;
        is_alu_func = f;
    endtask

    task automatic set_mul(input logic [5:0] tag, input logic [4:0] rob,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] f);
        is_valid     = 1'b1;
        is_is_mult   = 1'b1;
        is_tag       = tag;
        is_rob_idx   = rob;
        is_rs1_val   = a;
        is_rs2_val   = b;
        is_imm       = 32'hDEAD_BEEF;
        is_use_imm   = 1'b1;
        is_mult_func = f;
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [1:0] f);
        logic [63:0] pa;
        logic [63:0] pb;
        logic [63:0] p;
        pa = (f == 2'd1 || f == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        pb = (f == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = pa * pb;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    initial begin
        logic [3:0]  afn [10];
        logic [31:0] aex [10];
        logic [31:0] mex [4];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rf;
        int          k;

        afn = '{4'd1, 4'd2, 4'd3, 4'd9, 4'd7, 4'd8, 4'd4, 4'd5, 4'd6, 4'd12};
        aex = '{32'hFFFF_FFEC, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00,
                32'h0FFF_FFFF, 32'h0, 32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'h0};
        mex = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};

        reset        = 1'b0;
        squash       = 1'b0;
        is_valid     = 1'b0;
        is_tag       = '0;
        is_rob_idx   = '0;
        is_rs1_val   = '0;
        is_rs2_val   = '0;
        is_imm       = '0;
        is_use_imm   = 1'b0;
        is_is_mult   = 1'b0;
        is_alu_func  = '0;
        is_mult_func = '0;

        #2;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        chk("rst_ready", 64'(ex_is_ready), 64'd1);
        #5;
        reset = 1'b1;

        // Basic ADD, latency one
        set_alu(6'd33, 5'd2, 32'd5, 32'd3, 32'd0, 1'b0, 4'd0);
        push(6'd33, 5'd2, 32'd8, cyc + 1);
        tick();
        chk("add_valid", 64'(cdb_valid), 64'd1);
        idle();
        tick();
        chk("add_after", 64'(cdb_valid), 64'd0);

        // Immediate ALU ops back to back (buffer drains and refills)
        for (int i = 0; i < 10; i++) begin
            set_alu(6'(i + 1), 5'(i), 32'hFFFF_FFF0, 32'h1F, 32'd4,
                    1'b1, afn[i]);
            push(6'(i + 1), 5'(i), aex[i], cyc + 1);
            tick();
        end
        idle();
        tick();

        // Four multiplies back to back
        for (int i = 0; i < 4; i++) begin
            set_mul(6'(20 + i), 5'(10 + i), 32'hFFFF_FFFF, 32'd2, 2'(i));
            push(6'(20 + i), 5'(10 + i), mex[i], cyc + MS);
            tick();
        end
        idle();
        for (int i = 0; i < MS; i++) tick();

        // Random multiplies against reference product
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rf = 2'($urandom_range(0, 3));
            set_mul(6'(24 + i), 5'(i), ra, rb, rf);
            push(6'(24 + i), 5'(i), ref_mul(ra, rb, rf), cyc + MS);
            tick();
        end
        idle();
        for (int i = 0; i < MS; i++) tick();

        // Collision: mult reaches last stage as ALU result lands
        set_mul(6'd40, 5'd1, 32'd3, 32'd5, 2'd0);
        push(6'd40, 5'd1, 32'd15, cyc + MS);
        tick();
        idle();
        tick();
        tick();
        set_alu(6'd41, 5'd3, 32'd1, 32'd1, 32'd0, 1'b0, 4'd0);
        chk("col_ready_pre", 64'(ex_is_ready), 64'd1);
        push(6'd41, 5'd3, 32'd2, cyc + 2);
        tick();
        chk("col_ready_blk", 64'(ex_is_ready), 64'd0);
        idle();
        tick();
        chk("col_ready_post", 64'(ex_is_ready), 64'd1);
        tick();

        // Backpressure: full ALU buffer blocks issue until mults drain
        k = cyc;
        set_mul(6'd42, 5'd4, 32'd7, 32'd7, 2'd0);
        push(6'd42, 5'd4, 32'd49, k + MS);
        tick();
        set_mul(6'd43, 5'd5, 32'd8, 32'd8, 2'd0);
        push(6'd43, 5'd5, 32'd64, k + MS + 1);
        tick();
        set_mul(6'd44, 5'd6, 32'd9, 32'd9, 2'd0);
        push(6'd44, 5'd6, 32'd81, k + MS + 2);
        tick();
        set_alu(6'd45, 5'd7, 32'd7, 32'd9, 32'd0, 1'b0, 4'd0);
        chk("bp_ready_in", 64'(ex_is_ready), 64'd1);
        push(6'd45, 5'd7, 32'd16, k + 7);
        tick();
        set_mul(6'd46, 5'd8, 32'd10, 32'd10, 2'd0);
        chk("bp_ready_0", 64'(ex_is_ready), 64'd0);
        tick();
        chk("bp_ready_1", 64'(ex_is_ready), 64'd0);
        tick();
        chk("bp_ready_2", 64'(ex_is_ready), 64'd0);
        tick();
        chk("bp_ready_3", 64'(ex_is_ready), 64'd1);
        push(6'd46, 5'd8, 32'd100, cyc + MS);
        tick();
        idle();
        chk("bp_ready_4", 64'(ex_is_ready), 64'd1);
        for (int i = 0; i < MS; i++) tick();

        // Squash with a mult in flight and a full ALU buffer
        set_mul(6'd50, 5'd9, 32'd11, 32'd11, 2'd0);
        tick();
        set_alu(6'd51, 5'd10, 32'd1, 32'd2, 32'd0, 1'b0, 4'd0);
        tick(1'b1);
        set_alu(6'd53, 5'd11, 32'd3, 32'd4, 32'd0, 1'b0, 4'd0);
        tick();
        idle();
        chk("sq_ready", 64'(ex_is_ready), 64'd1);
        for (int i = 0; i < MS + 2; i++) tick();

        // Asynchronous reset between edges with mults in flight
        set_mul(6'd60, 5'd12, 32'd12, 32'd12, 2'd0);
        tick();
        set_mul(6'd61, 5'd13, 32'd13, 32'd13, 2'd3);
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 64'(cdb_valid), 64'd0);
        chk("arst_tag", 64'(cdb_tag), 64'd0);
        chk("arst_rob", 64'(cdb_rob_idx), 64'd0);
        chk("arst_value", 64'(cdb_value), 64'd0);
        chk("arst_ready", 64'(ex_is_ready), 64'd1);
        #1;
        reset = 1'b1;
        for (int i = 0; i < MS + 2; i++) tick();
        chk("end_ready", 64'(ex_is_ready), 64'd1);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
